// File: rtl/cpu_step_sequencer.sv
// rtl/cpu_step_sequencer.sv - microstep (T-state) sequencer with halt-flag JK command generation
module cpu_step_sequencer #(
    parameter int unsigned STEPS = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run,
    input  logic             step_req,
    input  logic             early_end,
    input  logic             halt_in,
    input  logic             resume,
    output logic [2:0]       t_idx,
    output logic [STEPS-1:0] t_onehot,
    output logic             fetch,
    output logic             instr_done,
    output logic             busy,
    output logic             halted,
    output logic             hlt_j_n,
    output logic             hlt_k_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SINGLE = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    state_e     state_q, state_d;
    logic [2:0] t_idx_q, t_idx_d;
    logic       done_q, done_d;
    logic       j_n_q, j_n_d;
    logic       k_n_q, k_n_d;
    logic       step_prev_q, step_prev_d;
    logic       step_rise;
    logic       instr_end;

    assign step_rise = step_req & ~step_prev_q;
    assign instr_end = halt_in | early_end | (t_idx_q == LAST_STEP);

    always_comb begin
        state_d     = state_q;
        t_idx_d     = t_idx_q;
        done_d      = 1'b0;
        j_n_d       = 1'b1;
        k_n_d       = 1'b1;
        step_prev_d = step_prev_q;
        if (ena) begin
            step_prev_d = step_req;
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d = S_RUN;
                    end else if (step_rise) begin
                        state_d = S_SINGLE;
                    end
                end
                S_RUN, S_SINGLE: begin
                    if (instr_end) begin
                        t_idx_d = 3'd0;
                        done_d  = 1'b1;
                        // halt outranks both early_end and a pending run request
                        if (halt_in) begin
                            state_d = S_HALTED;
                            j_n_d   = 1'b0;
                        end else begin
                            state_d = run ? S_RUN : S_IDLE;
                        end
                    end else begin
                        t_idx_d = t_idx_q + 3'd1;
                    end
                end
                S_HALTED: begin
                    t_idx_d = 3'd0;
                    if (resume) begin
                        state_d = S_IDLE;
                        k_n_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    t_idx_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            t_idx_q     <= 3'd0;
            done_q      <= 1'b0;
            j_n_q       <= 1'b1;
            k_n_q       <= 1'b1;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_idx_q     <= t_idx_d;
            done_q      <= done_d;
            j_n_q       <= j_n_d;
            k_n_q       <= k_n_d;
            step_prev_q <= step_prev_d;
        end
    end

    // Pulses are masked while frozen so a stalled cycle never repeats a command.
    assign t_idx      = t_idx_q;
    assign t_onehot   = {{(STEPS-1){1'b0}}, 1'b1} << t_idx_q;
    assign fetch      = (t_idx_q < 3'd2);
    assign instr_done = done_q & ena;
    assign busy       = (state_q == S_RUN) || (state_q == S_SINGLE);
    assign halted     = (state_q == S_HALTED);
    assign hlt_j_n    = j_n_q | ~ena;
    assign hlt_k_n    = k_n_q | ~ena;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// tb/tb_cpu_step_sequencer.sv - directed self-checking bench for cpu_step_sequencer
module tb_cpu_step_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       run;
    logic       step_req;
    logic       early_end;
    logic       halt_in;
    logic       resume;
    logic [2:0] t_idx;
    logic [5:0] t_onehot;
    logic       fetch;
    logic       instr_done;
    logic       busy;
    logic       halted;
    logic       hlt_j_n;
    logic       hlt_k_n;

    logic       jk_q;
    logic       toggle_seen;
    int         checks;
    int         errors;

    cpu_step_sequencer #(.STEPS(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .run        (run),
        .step_req   (step_req),
        .early_end  (early_end),
        .halt_in    (halt_in),
        .resume     (resume),
        .t_idx      (t_idx),
        .t_onehot   (t_onehot),
        .fetch      (fetch),
        .instr_done (instr_done),
        .busy       (busy),
        .halted     (halted),
        .hlt_j_n    (hlt_j_n),
        .hlt_k_n    (hlt_k_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External halt-status JK flip-flop with active-low J/K
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jk_q <= 1'b0;
        end else begin
            case ({hlt_j_n, hlt_k_n})
                2'b01:   jk_q <= 1'b1;
                2'b10:   jk_q <= 1'b0;
                2'b00:   jk_q <= ~jk_q;
                default: jk_q <= jk_q;
            endcase
        end
    end

    initial toggle_seen = 1'b0;
    always @(negedge clk) begin
        if (!hlt_j_n && !hlt_k_n) toggle_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_t"},      32'(t_idx), 32'd0);
        chk({tag, "_oh"},     32'(t_onehot), 32'd1);
        chk({tag, "_fetch"},  32'(fetch), 32'd1);
        chk({tag, "_done"},   32'(instr_done), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_jn"},     32'(hlt_j_n), 32'd1);
        chk({tag, "_kn"},     32'(hlt_k_n), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] seq_t [8];
        logic       seq_d [8];
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        ena       = 1'b1;
        run       = 1'b0;
        step_req  = 1'b0;
        early_end = 1'b0;
        halt_in   = 1'b0;
        resume    = 1'b0;
        seq_t = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        seq_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        cyc();
        cyc();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy), 32'd0);

        // free run: sequence observed from the cycle before run takes effect
        for (int i = 0; i < 8; i++) begin
            if (i == 0) run = 1'b1;
            if (i > 0) cyc();
            if (i > 0) begin
                chk($sformatf("run_t%0d", i), 32'(t_idx), 32'(seq_t[i]));
                chk($sformatf("run_done%0d", i), 32'(instr_done), 32'(seq_d[i]));
                chk($sformatf("run_fetch%0d", i), 32'(fetch), 32'(seq_t[i] < 3'd2));
                chk($sformatf("run_oh%0d", i), 32'(t_onehot), 32'(6'd1 << seq_t[i]));
            end
        end

        // early end at step 3, then run drop at step 2
        cyc(); chk("ee_t1", 32'(t_idx), 32'd1);
        chk("ee_done_clr", 32'(instr_done), 32'd0);
        cyc(); chk("ee_t2", 32'(t_idx), 32'd2);
        cyc(); chk("ee_t3", 32'(t_idx), 32'd3);
        early_end = 1'b1;
        cyc(); chk("ee_wrap_t", 32'(t_idx), 32'd0);
        chk("ee_wrap_done", 32'(instr_done), 32'd1);
        chk("ee_busy", 32'(busy), 32'd1);
        early_end = 1'b0;
        cyc(); chk("drop_t1", 32'(t_idx), 32'd1);
        cyc(); chk("drop_t2", 32'(t_idx), 32'd2);
        run = 1'b0;
        for (int i = 3; i <= 5; i++) begin
            cyc();
            chk($sformatf("drop_t%0d", i), 32'(t_idx), 32'(i));
            chk($sformatf("drop_busy%0d", i), 32'(busy), 32'd1);
        end
        cyc(); chk("drop_end_t", 32'(t_idx), 32'd0);
        chk("drop_end_done", 32'(instr_done), 32'd1);
        chk("drop_end_busy", 32'(busy), 32'd0);
        cyc(); chk("idle_t", 32'(t_idx), 32'd0);
        chk("idle_done", 32'(instr_done), 32'd0);

        // single instruction with step_req held high
        step_req = 1'b1;
        cyc(); chk("sgl_t0", 32'(t_idx), 32'd0);
        chk("sgl_busy0", 32'(busy), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("sgl_t%0d", i), 32'(t_idx), 32'(i));
            chk($sformatf("sgl_busy%0d", i), 32'(busy), 32'd1);
        end
        cyc(); chk("sgl_end_t", 32'(t_idx), 32'd0);
        chk("sgl_end_done", 32'(instr_done), 32'd1);
        chk("sgl_end_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("sgl_hold_busy%0d", i), 32'(busy), 32'd0);
            chk($sformatf("sgl_hold_t%0d", i), 32'(t_idx), 32'd0);
        end
        step_req = 1'b0;

        // halt together with early_end at step 2
        run = 1'b1;
        cyc(); chk("h_t0", 32'(t_idx), 32'd0);
        cyc(); chk("h_t1", 32'(t_idx), 32'd1);
        cyc(); chk("h_t2", 32'(t_idx), 32'd2);
        halt_in = 1'b1;
        early_end = 1'b1;
        cyc();
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_t", 32'(t_idx), 32'd0);
        chk("h_done", 32'(instr_done), 32'd1);
        chk("h_jn", 32'(hlt_j_n), 32'd0);
        chk("h_kn", 32'(hlt_k_n), 32'd1);
        chk("h_busy", 32'(busy), 32'd0);
        halt_in = 1'b0;
        early_end = 1'b0;
        cyc();
        chk("h_jn_end", 32'(hlt_j_n), 32'd1);
        chk("h_q_set", 32'(jk_q), 32'd1);
        chk("h_stay", 32'(halted), 32'd1);
        chk("h_done_clr", 32'(instr_done), 32'd0);
        run = 1'b0;
        cyc(); chk("h_hold_t", 32'(t_idx), 32'd0);
        chk("h_hold", 32'(halted), 32'd1);
        resume = 1'b1;
        cyc();
        chk("r_halted", 32'(halted), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_kn", 32'(hlt_k_n), 32'd0);
        chk("r_jn", 32'(hlt_j_n), 32'd1);
        resume = 1'b0;
        cyc();
        chk("r_kn_end", 32'(hlt_k_n), 32'd1);
        chk("r_q_clr", 32'(jk_q), 32'd0);

        // clock enable freeze at step 4
        run = 1'b1;
        cyc(); chk("en_t0", 32'(t_idx), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("en_t%0d", i), 32'(t_idx), 32'(i));
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("frz_t%0d", i), 32'(t_idx), 32'd4);
            chk($sformatf("frz_oh%0d", i), 32'(t_onehot), 32'h10);
            chk($sformatf("frz_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("frz_done%0d", i), 32'(instr_done), 32'd0);
        end
        ena = 1'b1;
        cyc(); chk("en_t5", 32'(t_idx), 32'd5);
        cyc(); chk("en_wrap_t", 32'(t_idx), 32'd0);
        chk("en_wrap_done", 32'(instr_done), 32'd1);

        // asynchronous reset mid-instruction
        cyc(); chk("ar_t1", 32'(t_idx), 32'd1);
        cyc(); chk("ar_t2", 32'(t_idx), 32'd2);
        cyc(); chk("ar_t3", 32'(t_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        run = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_busy", 32'(busy), 32'd0);

        chk("no_toggle", 32'(toggle_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_step_sequencer.md
# cpu_step_sequencer

Microstep (T-state) sequencer for the 8-bit CPU control unit. It advances the current step index through each instruction, ends instructions early on decoder request, and supports free-run, single-instruction stepping and HLT. It also sequences the external active-low JK flip-flop that holds the CPU "halted" status flag, issuing set and clear commands and never issuing toggle.

## Interface
- `STEPS`, default 6: microsteps per instruction. Legal range is 2..8.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: clock enable. When 0, all state and outputs are frozen and one-cycle pulses are forced to 0.
- `run`, input, 1: level; free-run request.
- `step_req`, input, 1: single-instruction request. Acts on its rising edge, detected internally with a registered previous value.
- `early_end`, input, 1: decoder flag; the current step is the last step of this instruction.
- `halt_in`, input, 1: decoder flag; HLT is executing in the current step.
- `resume`, input, 1: level; leave the HALTED state.
- `t_idx`, output, 3: current step index, 0..STEPS-1.
- `t_onehot`, output, STEPS: one-hot decode of `t_idx`.
- `fetch`, output, 1: high when `t_idx` < 2.
- `instr_done`, output, 1: one-cycle pulse; high in the cycle after an instruction ends.
- `busy`, output, 1: high in RUN or SINGLE.
- `halted`, output, 1: high in HALTED.
- `hlt_j_n`, `hlt_k_n`, output, 1 each: active-low J/K commands to the halt-status JK flip-flop.

## Operation
- States: IDLE, RUN, SINGLE, HALTED.
- Reset values: IDLE, `t_idx`=0, `t_onehot`=1, `fetch`=1, `instr_done`=0, `busy`=0, `halted`=0, `hlt_j_n`=1, `hlt_k_n`=1, step-edge register=0.
- Advance, in RUN or SINGLE only:
  - If `halt_in`, or `early_end`, or `t_idx`==STEPS-1: the instruction ends. `t_idx` goes to 0.
  - Otherwise `t_idx` increments by 1.
  - `t_idx` never exceeds STEPS-1.
- Transitions, evaluated when `ena`=1:
  - IDLE → RUN when `run`=1. No advance on the entry edge.
  - IDLE → SINGLE on a `step_req` rising edge with `run`=0. If both occur together, RUN wins.
  - RUN: advances every enabled cycle. If `run`=0 at an instruction end, go to IDLE. A `run` drop mid-instruction finishes the instruction first. `step_req` is ignored.
  - SINGLE: advances until the instruction ends, then goes to RUN if `run`=1, otherwise IDLE.
  - RUN/SINGLE with `halt_in`=1 at an advance → HALTED. `halt_in` has priority over `early_end` and over `run`.
  - HALTED: `t_idx` is held at 0. When `resume`=1, go to IDLE. `run`, `step_req`, `halt_in` and `early_end` are ignored.
- `instr_done` is registered. It is set on the same edge that wraps `t_idx` to 0, including on HALTED entry.
- JK command rules:
  - Default hold: `hlt_j_n`=1, `hlt_k_n`=1.
  - Set: `hlt_j_n`=0 for exactly one cycle following HALTED entry.
  - Clear: `hlt_k_n`=0 for exactly one cycle following HALTED → IDLE.
  - Both low (toggle) is never driven.
  - Both commands are registered, so the JK flip-flop captures the command on the next edge.
- `halt_in` and `early_end` are ignored outside RUN/SINGLE.

## Timing
- Step latency: 1 cycle per advance. An instruction of k steps takes k cycles.
- `t_onehot`, `fetch`, `busy` and `halted` are decoded from registered state, glitch-free, and valid in the same cycle as the state.
- HALTED entry at edge E:
  - `halted`=1, `instr_done`=1 and `hlt_j_n`=0 during cycle E..E+1.
  - At edge E+1 the external JK flip-flop Q becomes 1.
- Resume at edge R: `hlt_k_n`=0 during R..R+1, so the external Q becomes 0 at edge R+1.
- `ena`=0 for any number of cycles resumes exactly where it stopped. A pending `step_req` edge is not lost, because the edge register also freezes.
- Asserting `rst_n` mid-instruction or mid-JK-command returns everything to reset values immediately. JK commands return to hold (1,1).

## Test plan
- Reset, then `run`=1 with no flags: `t_idx` sequence 0,0,1,2,3,4,5,0. `instr_done`=1 only in the cycle after 5→0. `fetch`=1 only at `t_idx` 0/1.
- RUN with `early_end`=1 at `t_idx`=3: the next `t_idx` is 0 and `instr_done` pulses. Then drop `run` at `t_idx`=2: the sequencer completes 3,4,5,0 and enters IDLE with `busy`=0.
- IDLE, `step_req` pulse: exactly one 6-step instruction runs, then IDLE. Holding `step_req` high does not start a second instruction.
- `halt_in`=1 together with `early_end`=1 at `t_idx`=2:
  - Next cycle `halted`=1, `t_idx`=0, `hlt_j_n`=0 for one cycle, and the JK model Q=1.
  - `resume` gives `hlt_k_n`=0 for one cycle, Q=0 and state IDLE.
  - `hlt_j_n` and `hlt_k_n` are never both 0.
- `ena`=0 for 3 cycles at `t_idx`=4: all outputs are frozen, then the sequence continues at 5.
- `rst_n` low at `t_idx`=3, asynchronously between clock edges: outputs show reset values immediately.
